router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 No parameters; the state encoding is fixed inside the block.
REQ-002 clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pkt_valid  input  1  source is driving packet bytes; deassertion marks the parity byte.
REQ-005 data_in  input  2  destination address, i.e. header byte bits [1:0].
REQ-006 fifo_full  input  1  currently addressed destination FIFO is full.
REQ-007 fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  per-destination FIFO empty flags.
REQ-008 soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-destination packet-abort requests.
REQ-009 parity_done  input  1  parity byte is captured by the register block.
REQ-010 low_pkt_valid  input  1  register block has recorded the pkt_valid fall.
REQ-011 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  one-hot state strobes to the register block.
REQ-012 write_enb_reg  output  1  write strobe for the destination FIFO.
REQ-013 busy  output  1  source must hold its current byte.
REQ-014 dest  output  2  latched destination address of the packet in flight.

Function
REQ-015 The block SHALL implement a Moore FSM with states DA (decode address), LFD (load first data), LD (load data), FFS (FIFO full), LAF (load after full), LP (load parity), CPE (check parity error), WTE (wait till empty).
REQ-016 In DA with pkt_valid=1 and data_in<3, dest SHALL load data_in, and the next state SHALL be LFD if fifo_empty_[data_in]=1, else WTE.
REQ-017 In DA with pkt_valid=0, the FSM SHALL hold DA and dest SHALL hold its value.
REQ-018 Transitions: LFD->LD unconditionally. LD->FFS if fifo_full; else LD->LP if !pkt_valid; else hold LD (fifo_full has priority over !pkt_valid).
REQ-019 Transitions: FFS->LAF when !fifo_full, else hold. LAF->DA if parity_done; else LAF->LP if low_pkt_valid; else LAF->LD.
REQ-020 Transitions: LP->CPE unconditionally. CPE->FFS if fifo_full, else CPE->DA. WTE->LFD when fifo_empty_[dest]=1, else hold.
REQ-021 When soft_reset_[dest]=1 in any state other than DA, the next state SHALL be DA, overriding every other transition; soft resets for other destinations SHALL be ignored.
REQ-022 Output strobes, all registered-state decodes with zero additional latency:
- detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE.
- write_enb_reg=LD|LP|LAF.
- busy=1 in every state except DA and LD.
REQ-023 Exactly one strobe of the set {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} SHALL be high in DA/LFD/LD/LAF/FFS/CPE; all six SHALL be low in LP and WTE.

Reset
REQ-024 reset=1 at a rising edge SHALL force state DA and dest=0 regardless of any other input, including mid-packet.
REQ-025 After reset, outputs SHALL be detect_add=1, with every other strobe, write_enb_reg and busy at 0.

Configuration
REQ-026 Macro ROUTER_FSM_ADDR_CHECK_EN selects the handling of header address 3.
REQ-027 With ROUTER_FSM_ADDR_CHECK_EN defined:
- DA with pkt_valid=1 and data_in=3 SHALL go to an added state DROP, with busy=0, write_enb_reg=0 and all strobes 0.
- DROP SHALL hold while pkt_valid=1 and return to DA on the first cycle with pkt_valid=0.
REQ-028 Without ROUTER_FSM_ADDR_CHECK_EN, DA with data_in=3 SHALL hold DA, dest SHALL be unchanged, and no DROP state SHALL exist.

Verification
REQ-029 Reset, then pkt_valid=1, data_in=2'b01, fifo_empty_1=1, no fifo_full, pkt_valid low after 4 payload cycles -> DA,LFD,LD×4,LP,CPE,DA; dest=1; write_enb_reg high for 5 cycles.
REQ-030 fifo_full=1 during the 2nd LD cycle for 3 cycles, low_pkt_valid=0, parity_done=0 -> LD,FFS×3,LAF,LD; busy=1 throughout FFS and LAF.
REQ-031 data_in=2'b10 with fifo_empty_2=0 for 5 cycles, then 1 -> WTE×5 then LFD; busy=1 in WTE.
REQ-032 soft_reset_0 pulsed in LD with dest=0 -> DA next cycle; the same pulse with dest=1 -> no effect.
REQ-033 With ROUTER_FSM_ADDR_CHECK_EN, header data_in=2'b11 then 6 cycles of pkt_valid=1 -> DROP×6 then DA, write_enb_reg=0 throughout; without the macro -> remains DA.
REQ-034 reset=1 asserted in FFS -> DA on the next edge with detect_add=1 and dest=0.

Source files
------------

// File: rtl/router_fsm_if.sv
// Handshake bundle between the router FSM and its source/register/FIFO neighbours.
// master drives packet and FIFO status; slave is the FSM producing the strobes.
interface router_fsm_if;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic       write_enb_reg;
   logic       busy;
   logic [1:0] dest;

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      input  write_enb_reg, busy, dest
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      output write_enb_reg, busy, dest
   );
endinterface

// File: rtl/router_fsm.sv
// Packet router control FSM (Moore): decodes the header address, sequences payload/parity loads.
// Define ROUTER_FSM_ADDR_CHECK_EN to route headers addressed to 3 into a DROP state.
module router_fsm (
   input  logic        clock,
   input  logic        reset,
   router_fsm_if.slave bus
);

`ifdef ROUTER_FSM_ADDR_CHECK_EN
   typedef enum logic [3:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE, DROP} state_t;
`else
   typedef enum logic [3:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE} state_t;
`endif

   state_t     state;
   state_t     next_state;
   logic [1:0] dest;
   logic [1:0] dest_next;
   logic       hdr_empty;
   logic       dest_empty;
   logic       dest_soft_reset;

   // Address 3 has no destination, so it selects nothing.
   function automatic logic pick(input logic [1:0] sel, input logic a, input logic b,
                                 input logic c);
      case (sel)
         2'd0:    pick = a;
         2'd1:    pick = b;
         2'd2:    pick = c;
         default: pick = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= DA;
         dest  <= 2'd0;
      end else begin
         state <= next_state;
         dest  <= dest_next;
      end
   end

   always_comb begin
      hdr_empty       = pick(bus.data_in, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
      dest_empty      = pick(dest, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
      dest_soft_reset = pick(dest, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2);
   end

   always_comb begin
      next_state = state;
      dest_next  = dest;
      unique case (state)
         DA: begin
            if (bus.pkt_valid) begin
               if (bus.data_in != 2'd3) begin
                  dest_next  = bus.data_in;
                  next_state = hdr_empty ? LFD : WTE;
               end
`ifdef ROUTER_FSM_ADDR_CHECK_EN
               else begin
                  next_state = DROP;
               end
`endif
            end
         end
         LFD: next_state = LD;
         LD: begin
            if (bus.fifo_full)
               next_state = FFS;
            else if (!bus.pkt_valid)
               next_state = LP;
         end
         FFS: begin
            if (!bus.fifo_full)
               next_state = LAF;
         end
         LAF: begin
            if (bus.parity_done)
               next_state = DA;
            else if (bus.low_pkt_valid)
               next_state = LP;
            else
               next_state = LD;
         end
         LP:  next_state = CPE;
         CPE: next_state = bus.fifo_full ? FFS : DA;
         WTE: begin
            if (dest_empty)
               next_state = LFD;
         end
`ifdef ROUTER_FSM_ADDR_CHECK_EN
         DROP: begin
            if (!bus.pkt_valid)
               next_state = DA;
         end
`endif
         default: next_state = DA;
      endcase
      // Only the abort for the packet in flight matters, and it beats every other exit.
      if (state != DA && dest_soft_reset)
         next_state = DA;
   end

   always_comb begin
      bus.detect_add    = 1'b0;
      bus.lfd_state     = 1'b0;
      bus.ld_state      = 1'b0;
      bus.laf_state     = 1'b0;
      bus.full_state    = 1'b0;
      bus.rst_int_reg   = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.busy          = 1'b0;
      bus.dest          = dest;
      unique case (state)
         DA:  bus.detect_add = 1'b1;
         LFD: begin
            bus.lfd_state = 1'b1;
            bus.busy      = 1'b1;
         end
         LD: begin
            bus.ld_state      = 1'b1;
            bus.write_enb_reg = 1'b1;
         end
         FFS: begin
            bus.full_state = 1'b1;
            bus.busy       = 1'b1;
         end
         LAF: begin
            bus.laf_state     = 1'b1;
            bus.write_enb_reg = 1'b1;
            bus.busy          = 1'b1;
         end
         LP: begin
            bus.write_enb_reg = 1'b1;
            bus.busy          = 1'b1;
         end
         CPE: begin
            bus.rst_int_reg = 1'b1;
            bus.busy        = 1'b1;
         end
         WTE: bus.busy = 1'b1;
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks packets through every state and checks the decoded outputs.
module tb_router_fsm;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   router_fsm_if bus ();

   router_fsm dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Strobe patterns: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}.
   localparam logic [7:0] S_DA   = 8'b1000_0000;
   localparam logic [7:0] S_LFD  = 8'b0100_0001;
   localparam logic [7:0] S_LD   = 8'b0010_0010;
   localparam logic [7:0] S_LAF  = 8'b0001_0011;
   localparam logic [7:0] S_FFS  = 8'b0000_1001;
   localparam logic [7:0] S_CPE  = 8'b0000_0101;
   localparam logic [7:0] S_LP   = 8'b0000_0011;
   localparam logic [7:0] S_WTE  = 8'b0000_0001;
   localparam logic [7:0] S_DROP = 8'b0000_0000;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [7:0] strobes, input logic [1:0] dest);
      logic [9:0] observed;
      logic [9:0] expected;
      observed = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                  bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.dest};
      expected = {strobes, dest};
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic step_check(input string tag, input logic [7:0] strobes, input logic [1:0] dest);
      tick();
      check_output(tag, strobes, dest);
   endtask

   initial begin
      vectors           = 0;
      miscompares       = 0;
      reset             = 1'b1;
      bus.pkt_valid     = 1'b0;
      bus.data_in       = 2'd0;
      bus.fifo_full     = 1'b0;
      bus.fifo_empty_0  = 1'b1;
      bus.fifo_empty_1  = 1'b1;
      bus.fifo_empty_2  = 1'b0;
      bus.soft_reset_0  = 1'b0;
      bus.soft_reset_1  = 1'b0;
      bus.soft_reset_2  = 1'b0;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;

      tick();
      tick();
      check_output("reset", S_DA, 2'd0);

      // Plain packet to destination 1 with four payload cycles.
      reset         = 1'b0;
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd1;
      step_check("p1_lfd", S_LFD, 2'd1);
      step_check("p1_ld1", S_LD, 2'd1);
      step_check("p1_ld2", S_LD, 2'd1);
      step_check("p1_ld3", S_LD, 2'd1);
      step_check("p1_ld4", S_LD, 2'd1);
      bus.pkt_valid = 1'b0;
      step_check("p1_lp", S_LP, 2'd1);
      step_check("p1_cpe", S_CPE, 2'd1);
      step_check("p1_da", S_DA, 2'd1);
      bus.data_in = 2'd2;
      step_check("idle_hold", S_DA, 2'd1);

      // Destination FIFO fills mid-payload, then parity bookkeeping paths out of LAF.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd0;
      step_check("p2_lfd", S_LFD, 2'd0);
      step_check("p2_ld1", S_LD, 2'd0);
      step_check("p2_ld2", S_LD, 2'd0);
      bus.fifo_full = 1'b1;
      step_check("p2_ffs1", S_FFS, 2'd0);
      step_check("p2_ffs2", S_FFS, 2'd0);
      step_check("p2_ffs3", S_FFS, 2'd0);
      bus.fifo_full = 1'b0;
      step_check("p2_laf", S_LAF, 2'd0);
      step_check("p2_ld3", S_LD, 2'd0);
      bus.pkt_valid = 1'b0;
      bus.fifo_full = 1'b1;
      step_check("p2_full_over_pv", S_FFS, 2'd0);
      bus.fifo_full     = 1'b0;
      step_check("p2_laf2", S_LAF, 2'd0);
      bus.low_pkt_valid = 1'b1;
      step_check("p2_lp", S_LP, 2'd0);
      bus.fifo_full     = 1'b1;
      step_check("p2_cpe", S_CPE, 2'd0);
      step_check("p2_cpe_ffs", S_FFS, 2'd0);
      bus.fifo_full     = 1'b0;
      step_check("p2_laf3", S_LAF, 2'd0);
      bus.parity_done   = 1'b1;
      step_check("p2_parity_da", S_DA, 2'd0);
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;

      // Destination 2 busy: wait for its FIFO while the others report empty.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd2;
      step_check("p3_wte1", S_WTE, 2'd2);
      bus.data_in   = 2'd0;
      step_check("p3_wte2", S_WTE, 2'd2);
      step_check("p3_wte3", S_WTE, 2'd2);
      step_check("p3_wte4", S_WTE, 2'd2);
      step_check("p3_wte5", S_WTE, 2'd2);
      bus.fifo_empty_2 = 1'b1;
      step_check("p3_lfd", S_LFD, 2'd2);
      step_check("p3_ld", S_LD, 2'd2);
      bus.soft_reset_0 = 1'b1;
      step_check("p3_sr_other", S_LD, 2'd2);
      bus.soft_reset_0 = 1'b0;
      bus.soft_reset_2 = 1'b1;
      step_check("p3_sr_own", S_DA, 2'd2);
      bus.soft_reset_2 = 1'b0;

      // Soft reset for destination 0 aborts only a packet headed to 0.
      bus.data_in      = 2'd0;
      step_check("p4_lfd", S_LFD, 2'd0);
      step_check("p4_ld", S_LD, 2'd0);
      bus.soft_reset_0 = 1'b1;
      step_check("p4_sr0", S_DA, 2'd0);
      bus.data_in      = 2'd1;
      bus.soft_reset_0 = 1'b0;
      step_check("p5_lfd", S_LFD, 2'd1);
      step_check("p5_ld", S_LD, 2'd1);
      bus.soft_reset_0 = 1'b1;
      step_check("p5_sr0_ignored", S_LD, 2'd1);
      bus.soft_reset_0 = 1'b0;
      bus.pkt_valid    = 1'b0;
      step_check("p5_lp", S_LP, 2'd1);
      bus.soft_reset_1 = 1'b1;
      step_check("p5_sr1_in_lp", S_DA, 2'd1);
      bus.soft_reset_1 = 1'b0;

      // Header addressed to 3.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd3;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
      for (int i = 0; i < 6; i++)
         step_check("a3_drop", S_DROP, 2'd1);
      bus.pkt_valid = 1'b0;
      step_check("a3_drop_exit", S_DA, 2'd1);
`else
      for (int i = 0; i < 6; i++)
         step_check("a3_hold", S_DA, 2'd1);
      bus.pkt_valid = 1'b0;
      step_check("a3_after", S_DA, 2'd1);
`endif

      // Reset in the middle of a stalled packet.
      bus.pkt_valid = 1'b1;
      bus.data_in   = 2'd2;
      step_check("p6_lfd", S_LFD, 2'd2);
      step_check("p6_ld", S_LD, 2'd2);
      bus.fifo_full = 1'b1;
      step_check("p6_ffs", S_FFS, 2'd2);
      reset = 1'b1;
      step_check("p6_reset", S_DA, 2'd0);
      reset         = 1'b0;
      bus.pkt_valid = 1'b0;
      bus.fifo_full = 1'b0;
      step_check("p6_idle", S_DA, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
